// File: rtl/imem_server.sv
// imem_server: instruction memory with a LATENCY-stage read pipeline feeding an
// RBUF_DEPTH-entry in-order response buffer under credit-based flow control.
// Optional feature macro: IMEM_MISALIGN_ERR_EN adds resp_err and zeroes the data
// of responses whose request address was not word aligned.
module imem_server #(
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 1,
    parameter int RBUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    input  logic [31:0]              req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic [31:0]              resp_data,
    input  logic                     resp_ready,
`ifdef IMEM_MISALIGN_ERR_EN
    output logic                     resp_err,
`endif
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = 4;              // occupancy + in-flight never exceeds 12
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Memory starts out filled with NOPs; it has no reset.
    logic [31:0] mem_q [DEPTH] = '{default: NOP};

    logic                  run_q, run_d;
    logic [LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
    logic [LATENCY-1:0]    pipe_err_q, pipe_err_d;
    logic [31:0]           pipe_data_q [LATENCY];
    logic [31:0]           pipe_data_d [LATENCY];
    logic [31:0]           buf_data_q [RBUF_DEPTH];
    logic [31:0]           buf_data_d [RBUF_DEPTH];
    logic [RBUF_DEPTH-1:0] buf_err_q, buf_err_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [CW-1:0]         inflight_s, credit_s, wr_idx_s;
    logic                  pop_s, push_s, accept_s, misalign_s, ready_s;
    logic [31:0]           push_data_s;
    logic                  unused_s;

    // Address bits that never select a word.
    assign unused_s = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Count requests still travelling through the read pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_s = inflight_s + CW'(pipe_vld_q[i]);
        end
    end

    // Credit check: an entry popping this cycle frees its slot for a new request,
    // which is what sustains one response per cycle once the pipe is full.
    always_comb begin
        run_d    = 1'b1;
        pop_s    = (occ_q != '0) && resp_ready;
        credit_s = occ_q + inflight_s - CW'(pop_s);
        ready_s  = run_q && (credit_s < CW'(RBUF_DEPTH));
        accept_s = req_valid && ready_s;
`ifdef IMEM_MISALIGN_ERR_EN
        misalign_s = (req_addr[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
    end

    // Read pipeline: stage 0 captures the word at acceptance (old data on a
    // same-cycle write), later stages just delay it.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_err_d     = '0;
        pipe_data_d    = '{default: 32'h0000_0000};
        pipe_vld_d[0]  = accept_s;
        pipe_err_d[0]  = accept_s && misalign_s;
        pipe_data_d[0] = mem_q[req_addr[AW+1:2]];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_err_d[i]  = pipe_err_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Response buffer: entry 0 is the registered output; pops shift the queue
    // down and a push lands just behind the last surviving entry.
    always_comb begin
        push_s      = pipe_vld_q[LATENCY-1];
        push_data_s = pipe_err_q[LATENCY-1] ? 32'h0000_0000 : pipe_data_q[LATENCY-1];
        buf_data_d  = buf_data_q;
        buf_err_d   = buf_err_q;
        if (pop_s) begin
            for (int i = 0; i < RBUF_DEPTH - 1; i++) begin
                buf_data_d[i] = buf_data_q[i+1];
                buf_err_d[i]  = buf_err_q[i+1];
            end
            wr_idx_s = occ_q - CW'(1);
        end else begin
            wr_idx_s = occ_q;
        end
        for (int i = 0; i < RBUF_DEPTH; i++) begin
            buf_data_d[i] = (push_s && (wr_idx_s == CW'(i))) ? push_data_s : buf_data_d[i];
            buf_err_d[i]  = (push_s && (wr_idx_s == CW'(i))) ? pipe_err_q[LATENCY-1] : buf_err_d[i];
        end
        occ_d = occ_q + CW'(push_s) - CW'(pop_s);
    end

    // State registers; reset throws away everything in flight or buffered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_err_q  <= '0;
            pipe_data_q <= '{default: 32'h0000_0000};
            buf_data_q  <= '{default: 32'h0000_0000};
            buf_err_q   <= '0;
            occ_q       <= '0;
        end else begin
            run_q       <= run_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_err_q  <= pipe_err_d;
            pipe_data_q <= pipe_data_d;
            buf_data_q  <= buf_data_d;
            buf_err_q   <= buf_err_d;
            occ_q       <= occ_d;
        end
    end

    // Memory load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // req_ready depends on resp_ready within the cycle so a pop can return its credit.
    assign req_ready  = ready_s;
    assign resp_valid = (occ_q != '0);
    assign resp_data  = buf_data_q[0];
`ifdef IMEM_MISALIGN_ERR_EN
    assign resp_err   = buf_err_q[0] && (occ_q != '0);
`endif

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: default instance (LATENCY=1, RBUF_DEPTH=2)
// plus a LATENCY=4 / RBUF_DEPTH=5 instance for the deep-pipeline throughput case.
module tb_imem_server;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, req_valid, req_ready, resp_valid, resp_ready, wr_en;
    logic [31:0] req_addr, resp_data, wr_data;
    logic [7:0]  wr_addr;
    logic        req4_valid, req4_ready, resp4_valid, resp4_ready, wr4_en;
    logic [31:0] req4_addr, resp4_data, wr4_data;
    logic [7:0]  wr4_addr;
`ifdef IMEM_MISALIGN_ERR_EN
    logic        resp_err, resp4_err;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_mem [256];
    logic [31:0] exp_q [$];
    logic        exp_err_q [$];

    imem_server dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready),
`ifdef IMEM_MISALIGN_ERR_EN
        .resp_err(resp_err),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_server #(.DEPTH(256), .LATENCY(4), .RBUF_DEPTH(5)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(req4_valid), .req_addr(req4_addr),
        .req_ready(req4_ready), .resp_valid(resp4_valid), .resp_data(resp4_data),
        .resp_ready(resp4_ready),
`ifdef IMEM_MISALIGN_ERR_EN
        .resp_err(resp4_err),
`endif
        .wr_en(wr4_en), .wr_addr(wr4_addr), .wr_data(wr4_data)
    );

    // One cycle on the default instance: drive, sample, push expectation on accept.
    task automatic do_cycle(input logic v, input logic [31:0] a, input logic rr,
                            output logic acc, output logic pop,
                            output logic [31:0] data, output logic err);
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        #1;
        acc  = v && req_ready;
        pop  = resp_valid && rr;
        data = resp_data;
`ifdef IMEM_MISALIGN_ERR_EN
        err = resp_err;
        if (acc) begin
            exp_q.push_back((a[1:0] != 2'b00) ? 32'h0000_0000 : model_mem[a[9:2]]);
            exp_err_q.push_back(a[1:0] != 2'b00);
        end
`else
        err = 1'b0;
        if (acc) begin
            exp_q.push_back(model_mem[a[9:2]]);
            exp_err_q.push_back(1'b0);
        end
`endif
        @(posedge clk);
        #1;
        if (wr_en) model_mem[wr_addr] = wr_data;
        wr_en     = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 00000000", resp_data); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise: got %b want 1", req_ready); end
        checks++; if (req4_ready !== 1'b1) begin failures++; $display("FAIL reset_ready4_rise: got %b want 1", req4_ready); end
    endtask

    task automatic test_basic();
        logic acc, pop, e, ee;
        logic [31:0] d, ed;
        logic [31:0] words [3] = '{32'h0050_0093, 32'h0070_0113, 32'h0020_81b3};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = words[i];
            do_cycle(1'b0, 32'h0, 1'b1, acc, pop, d, e);
        end
        for (int k = 0; k < 7; k++) begin
            do_cycle(k < 3, 32'(k * 4), 1'b1, acc, pop, d, e);
            if (k < 3) begin
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL basic_accept: cycle %0d got %b want 1", k, acc); end
            end
            checks++;
            if (pop !== (k >= 2 && k <= 4)) begin failures++; $display("FAIL basic_timing: cycle %0d resp_valid %b want %b", k, pop, (k >= 2 && k <= 4)); end
            if (pop) begin
                checks++;
                if (d !== words[k-2]) begin failures++; $display("FAIL basic_word: got %h want %h", d, words[k-2]); end
                if (exp_q.size() != 0) begin ed = exp_q.pop_front(); ee = exp_err_q.pop_front(); end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_drain: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic acc, pop, e, ee;
        logic [31:0] d, ed;
        int n_acc = 0;
        int n_pop = 0;
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b1, 32'(k * 4), 1'b0, acc, pop, d, e);
            if (acc) n_acc++;
            if (k >= 1) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_data !== 32'h0050_0093) begin
                    failures++; $display("FAIL bp_hold: got %b/%h want 1/00500093", resp_valid, resp_data);
                end
            end
        end
        checks++; if (n_acc != 2) begin failures++; $display("FAIL bp_accepts: got %0d want 2", n_acc); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b want 0", req_ready); end
        for (int k = 0; k < 6; k++) begin
            do_cycle(1'b0, 32'h0, 1'b1, acc, pop, d, e);
            if (pop) begin
                n_pop++;
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_data: unexpected %h", d); end
                else begin
                    ed = exp_q.pop_front(); ee = exp_err_q.pop_front();
                    if (d !== ed || e !== ee) begin failures++; $display("FAIL bp_data: got %h/%b want %h/%b", d, e, ed, ee); end
                end
            end
        end
        checks++; if (n_pop != 2) begin failures++; $display("FAIL bp_drain: got %0d want 2", n_pop); end
    endtask

    task automatic test_wrap_rbw();
        logic acc, pop, e, ee;
        logic [31:0] d, ed;
        logic [31:0] addrs [3] = '{32'h0000_0400, 32'h0000_0014, 32'h0000_0014};
        logic [31:0] want [3]  = '{32'h0050_0093, 32'h0000_0013, 32'hdead_beef};
        int n_pop = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hdead_beef; end
            do_cycle(k < 3, (k < 3) ? addrs[k] : 32'h0, 1'b1, acc, pop, d, e);
            if (pop) begin
                checks++;
                if (exp_q.size() == 0 || n_pop > 2) begin failures++; $display("FAIL wrap_data: unexpected %h", d); end
                else begin
                    ed = exp_q.pop_front(); ee = exp_err_q.pop_front();
                    if (d !== ed || d !== want[n_pop]) begin failures++; $display("FAIL wrap_data: got %h want %h", d, want[n_pop]); end
                end
                n_pop++;
            end
        end
        checks++; if (n_pop != 3) begin failures++; $display("FAIL wrap_count: got %0d want 3", n_pop); end
    endtask

    task automatic test_misalign();
        logic acc, pop, e, ee;
        logic [31:0] d, ed, want_d;
        logic want_e;
        int n_pop = 0;
`ifdef IMEM_MISALIGN_ERR_EN
        want_d = 32'h0000_0000; want_e = 1'b1;
`else
        want_d = 32'h0070_0113; want_e = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            do_cycle(k == 0, 32'h0000_0006, 1'b1, acc, pop, d, e);
            if (pop) begin
                n_pop++;
                checks++;
                if (exp_q.size() != 0) begin ed = exp_q.pop_front(); ee = exp_err_q.pop_front(); end
                if (d !== want_d || e !== want_e) begin failures++; $display("FAIL misalign: got %h/%b want %h/%b", d, e, want_d, want_e); end
            end
        end
        checks++; if (n_pop != 1) begin failures++; $display("FAIL misalign_count: got %0d want 1", n_pop); end
    endtask

    task automatic test_latency4();
        logic [31:0] exp4_q [$];
        logic [31:0] ed;
        int first_pop = -1;
        int n_pop = 0;
        int n_acc = 0;
        logic gap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr4_en = 1'b1; wr4_addr = 8'(i); wr4_data = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
            @(posedge clk);
            #1;
        end
        wr4_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            req4_valid = (k < 8); req4_addr = 32'(k * 4); resp4_ready = 1'b1;
            #1;
            if (req4_valid && req4_ready) begin
                exp4_q.push_back(32'h1000_0000 + 32'(k) * 32'h0000_0101);
                n_acc++;
            end
            if (resp4_valid) begin
                if (first_pop < 0) first_pop = k;
                if (k != first_pop + n_pop) gap = 1'b1;
                n_pop++;
                checks++;
                if (exp4_q.size() == 0) begin failures++; $display("FAIL lat4_data: unexpected %h", resp4_data); end
                else begin
                    ed = exp4_q.pop_front();
                    if (resp4_data !== ed) begin failures++; $display("FAIL lat4_data: got %h want %h", resp4_data, ed); end
                end
            end
            @(posedge clk);
            #1;
        end
        req4_valid = 1'b0;
        checks++; if (n_acc != 8) begin failures++; $display("FAIL lat4_accepts: got %0d want 8", n_acc); end
        checks++; if (first_pop != 5) begin failures++; $display("FAIL lat4_first: cycle %0d want 5", first_pop); end
        checks++; if (n_pop != 8 || gap) begin failures++; $display("FAIL lat4_stream: pops %0d gap %b want 8/0", n_pop, gap); end
    endtask

    task automatic test_reset_midflight();
        logic acc, pop, e, ee;
        logic [31:0] d, ed;
        logic stale = 1'b0;
        int n_good = 0;
        for (int k = 0; k < 4; k++) begin
            do_cycle(k < 2, 32'(k * 4), 1'b0, acc, pop, d, e);
        end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rst_pre: resp_valid %b want 1", resp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rst_now: valid/ready %b/%b want 0/0", resp_valid, req_ready); end
        exp_q.delete();
        exp_err_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            do_cycle(1'b0, 32'h0, 1'b1, acc, pop, d, e);
            if (pop) stale = 1'b1;
        end
        checks++; if (stale) begin failures++; $display("FAIL rst_stale: stale response seen, want none"); end
        for (int k = 0; k < 4; k++) begin
            do_cycle(k == 0, 32'h0, 1'b1, acc, pop, d, e);
            if (pop) begin
                n_good++;
                checks++;
                if (exp_q.size() != 0) begin ed = exp_q.pop_front(); ee = exp_err_q.pop_front(); end
                if (d !== 32'h0050_0093) begin failures++; $display("FAIL rst_mem: got %h want 00500093", d); end
            end
        end
        checks++; if (n_good != 1) begin failures++; $display("FAIL rst_mem_count: got %0d want 1", n_good); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0000_0013;
        reset_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = 8'h0; wr_data = 32'h0;
        req4_valid = 1'b0; req4_addr = 32'h0; resp4_ready = 1'b0;
        wr4_en = 1'b0; wr4_addr = 8'h0; wr4_data = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_rbw();
        test_misalign();
        test_latency4();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
